// File: rtl/fsweep_pkg.sv
// Shared types and MISR step function for the fault-sweep controller.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package fsweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GOLDEN,
    SWEEP,
    REPORT,
    FINISH
  } state_e;

  // Stimulus phase within a pass: all-0, all-1, then alternating bits.
  typedef enum logic [1:0] {
    PH_ZERO,
    PH_ONE,
    PH_ALT
  } phase_e;

  // Widest signature the step function handles; narrower MISRs are masked.
  localparam int MISR_MAX_W = 32;
  localparam int MISR_IDX_W = $clog2(MISR_MAX_W);

  // One MISR step on a w-bit signature: shift, fold the polynomial in when
  // the bit shifted out was set, then xor the sampled outputs.
  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] poly,
    input logic [MISR_MAX_W-1:0] din,
    input int                    w
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_IDX_W-1:0] msb;
    msb  = MISR_IDX_W'(w - 1);
    mask = (w >= MISR_MAX_W) ? '1 : ((MISR_MAX_W'(1) << w) - MISR_MAX_W'(1));
    return (((sig << 1) ^ (sig[msb] ? poly : '0)) ^ din) & mask;
  endfunction

endpackage

// File: rtl/fsweep_misr.sv
// MISR compacting DUT outputs into a per-pass signature.
// Latency: sig_next is combinational; the register updates on the en edge.
// Backpressure: none; clr has priority over en.
//   clk, rst  clock, async active-high reset
//   clr       zero the signature (pass start)
//   en        absorb din this edge
//   din       DUT outputs (OUT_W <= SIG_W, zero-extended)
//   sig_next  signature including the sample absorbed this cycle
module fsweep_misr
  import fsweep_pkg::*;
#(
  parameter int               SIG_W     = 16,
  parameter int               OUT_W     = 7,
  parameter logic [SIG_W-1:0] MISR_POLY = 16'h8005
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] din,
  output logic [SIG_W-1:0] sig_next
);

  logic [SIG_W-1:0] sig;

  assign sig_next = SIG_W'(misr_next(MISR_MAX_W'(sig), MISR_MAX_W'(MISR_POLY),
                                     MISR_MAX_W'(din), SIG_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/fault_sweep_controller.sv
// Fault-campaign sequencer: golden pass, then one pass per fault ID, MISR compare.
// Latency: CYCLES*HOLD cycles per pass, +1 REPORT cycle per fault, +1 FINISH cycle.
// Backpressure: none; start is ignored unless idle.
//   start/fid_start/fid_end  campaign request, range [fid_start, fid_end)
//   stim/fault_id/fault_en   registered drive to the DUT; dut_out its response
//   busy/done                campaign status; done is a 1-cycle pulse
//   det_valid/det_fid/det_hit/det_count  per-fault result and running hit count
module fault_sweep_controller
  import fsweep_pkg::*;
#(
  parameter int               IN_W      = 11,
  parameter int               OUT_W     = 7,
  parameter int               FID_W     = 10,
  parameter int               CYCLES    = 512,
  parameter int               HOLD      = 4,
  parameter int               PH1_END   = 170,
  parameter int               PH2_END   = 340,
  parameter int               SIG_W     = 16,
  parameter logic [SIG_W-1:0] MISR_POLY = 16'h8005
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [FID_W-1:0] fid_start,
  input  logic [FID_W-1:0] fid_end,
  output logic [IN_W-1:0]  stim,
  output logic [FID_W-1:0] fault_id,
  output logic             fault_en,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             det_valid,
  output logic [FID_W-1:0] det_fid,
  output logic             det_hit,
  output logic [FID_W-1:0] det_count
);

  localparam int SW = $clog2(CYCLES + 1);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(CYCLES - 1);
  localparam logic [HW-1:0] LAST_HOLD = HW'(HOLD - 1);
  localparam logic [SW-1:0] PH1       = SW'(PH1_END);
  localparam logic [SW-1:0] PH2       = SW'(PH2_END);

  state_e           state, state_nxt;
  logic [SW-1:0]    step;
  logic [HW-1:0]    hold;
  logic [FID_W-1:0] fid, fid_nxt, fid_inc, fid_end_q;
  logic [SIG_W-1:0] sig_next, golden;
  logic             in_pass, sample, pass_end, pass_start, last_fid;

  function automatic logic [IN_W-1:0] stim_val(input logic [SW-1:0] s);
    phase_e          ph;
    logic [IN_W-1:0] v;
    v = '0;
    if (s < PH1)      ph = PH_ZERO;
    else if (s < PH2) ph = PH_ONE;
    else              ph = PH_ALT;
    case (ph)
      PH_ZERO: v = '0;
      PH_ONE:  v = '1;
      default: for (int k = 0; k < IN_W; k++) v[k] = s[0] ^ k[0];
    endcase
    return v;
  endfunction

  assign in_pass  = (state == GOLDEN) || (state == SWEEP);
  // Sample on the last hold cycle so stim has settled through the DUT.
  assign sample   = in_pass && (hold == LAST_HOLD);
  assign pass_end = sample && (step == LAST_STEP);
  assign fid_inc  = fid + FID_W'(1);
  // Range is non-empty in SWEEP, so fid_end_q >= 1 and fid_inc never wraps.
  assign last_fid = (fid_inc == fid_end_q);

  always_comb begin
    state_nxt  = state;
    fid_nxt    = fid;
    pass_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = GOLDEN;
          fid_nxt    = fid_start;
          pass_start = 1'b1;
        end
      end
      GOLDEN: begin
        if (pass_end) begin
          if (fid < fid_end_q) begin
            state_nxt  = SWEEP;
            pass_start = 1'b1;
          end else begin
            state_nxt = FINISH;
          end
        end
      end
      SWEEP: begin
        if (pass_end) state_nxt = REPORT;
      end
      REPORT: begin
        if (last_fid) begin
          state_nxt = FINISH;
        end else begin
          state_nxt  = SWEEP;
          fid_nxt    = fid_inc;
          pass_start = 1'b1;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step      <= '0;
      hold      <= '0;
      fid       <= '0;
      fid_end_q <= '0;
      golden    <= '0;
      stim      <= '0;
      fault_id  <= '0;
      fault_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      det_valid <= 1'b0;
      det_fid   <= '0;
      det_hit   <= 1'b0;
      det_count <= '0;
    end else begin
      fid <= fid_nxt;
      if ((state == IDLE) && start) begin
        fid_end_q <= fid_end;
        det_count <= '0;
      end

      if (pass_start) begin
        step <= '0;
        hold <= '0;
      end else if (sample) begin
        step <= step + SW'(1);
        hold <= '0;
      end else if (in_pass) begin
        hold <= hold + HW'(1);
      end

      // stim is parked at zero between passes.
      if (pass_start)             stim <= stim_val('0);
      else if (pass_end)          stim <= '0;
      else if (sample)            stim <= stim_val(step + SW'(1));

      fault_en <= (state_nxt == SWEEP);
      fault_id <= (state_nxt == SWEEP) ? fid_nxt : '0;
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == FINISH);

      if ((state == GOLDEN) && pass_end) golden <= sig_next;

      det_valid <= (state == SWEEP) && pass_end;
      if ((state == SWEEP) && pass_end) begin
        det_fid <= fid;
        det_hit <= (sig_next != golden);
        if ((sig_next != golden) && (det_count != '1)) begin
          det_count <= det_count + FID_W'(1);
        end
      end
    end
  end

  fsweep_misr #(
    .SIG_W    (SIG_W),
    .OUT_W    (OUT_W),
    .MISR_POLY(MISR_POLY)
  ) u_misr (
    .clk     (clk),
    .rst     (rst),
    .clr     (pass_start),
    .en      (sample),
    .din     (dut_out),
    .sig_next(sig_next)
  );

endmodule

// File: tb/tb_fault_sweep_controller.sv
// Bench for fault_sweep_controller: default-size instance driven by a
// behavioural gate-DUT stand-in, plus a short-pass instance for stim checks.
module tb_fault_sweep_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        start;
  logic [9:0]  fid_start, fid_end, fault_id, det_fid, det_count;
  logic [10:0] stim;
  logic [6:0]  dut_out;
  logic        fault_en, busy, done, det_valid, det_hit;

  // short-pass instance (HOLD=1, CYCLES=8)
  logic        start2;
  logic [9:0]  fid_start2, fid_end2, fault_id2, det_fid2, det_count2;
  logic [10:0] stim2;
  logic [6:0]  dut_out2;
  logic        fault_en2, busy2, done2, det_valid2, det_hit2;

  int checks = 0;
  int errors = 0;
  int fault_mode = 0;
  logic stim_chk = 1'b0;

  typedef struct {
    logic [9:0] fid;
    logic       hit;
    logic [9:0] cnt;
  } det_t;

  det_t        exp_q[$];
  det_t        exp2_q[$];
  logic [10:0] stim_q[$];
  det_t        det_e, det2_e;
  logic [10:0] stim_e;

  // expected det_hit per fault ID 0..3 for fault modes 0 (none), 1 (fid 2 flips bit 0), 2 (bit 3 stuck-at-0)
  bit hit_tab [3][4] = '{'{0, 0, 0, 0}, '{0, 0, 1, 0}, '{1, 1, 1, 1}};
  // HOLD=1, CYCLES=8, PH1_END=2, PH2_END=4; alternation phase bit k = (s+k) mod 2
  logic [10:0] stim_tab [8] = '{11'h000, 11'h000, 11'h7FF, 11'h7FF,
                                11'h2AA, 11'h555, 11'h2AA, 11'h555};

  always_comb begin
    dut_out = stim[6:0];
    if (fault_mode == 1 && fault_en && fault_id == 10'd2) dut_out[0] = ~stim[0];
    if (fault_mode == 2 && fault_en) dut_out[3] = 1'b0;
  end
  assign dut_out2 = stim2[6:0];

  fault_sweep_controller u_dut (
    .clk(clk), .rst(rst), .start(start), .fid_start(fid_start), .fid_end(fid_end),
    .stim(stim), .fault_id(fault_id), .fault_en(fault_en), .dut_out(dut_out),
    .busy(busy), .done(done), .det_valid(det_valid), .det_fid(det_fid),
    .det_hit(det_hit), .det_count(det_count)
  );

  fault_sweep_controller #(.HOLD(1), .CYCLES(8), .PH1_END(2), .PH2_END(4)) u_small (
    .clk(clk), .rst(rst), .start(start2), .fid_start(fid_start2), .fid_end(fid_end2),
    .stim(stim2), .fault_id(fault_id2), .fault_en(fault_en2), .dut_out(dut_out2),
    .busy(busy2), .done(done2), .det_valid(det_valid2), .det_fid(det_fid2),
    .det_hit(det_hit2), .det_count(det_count2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // det scoreboards
  always @(negedge clk) begin
    if (!rst && det_valid) begin
      if (exp_q.size() == 0) begin
        check("det_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        det_e = exp_q.pop_front();
        check("det_fid", 32'(det_fid), 32'(det_e.fid));
        check("det_hit", 32'(det_hit), 32'(det_e.hit));
        check("det_count", 32'(det_count), 32'(det_e.cnt));
        check("report_fault_off", 32'({fault_en, fault_id}), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && det_valid2) begin
      if (exp2_q.size() == 0) begin
        check("det2_unexpected", 32'(exp2_q.size()), 32'd1);
      end else begin
        det2_e = exp2_q.pop_front();
        check("det2_fid", 32'(det_fid2), 32'(det2_e.fid));
        check("det2_hit", 32'(det_hit2), 32'(det2_e.hit));
        check("det2_count", 32'(det_count2), 32'(det2_e.cnt));
      end
    end
  end

  // stim monitor for the short-pass instance
  always @(negedge clk) begin
    if (!rst && stim_chk && busy2 && !done2) begin
      if (stim_q.size() == 0) begin
        check("stim_extra", 32'(stim_q.size()), 32'd1);
      end else begin
        stim_e = stim_q.pop_front();
        check("stim_step", 32'(stim2), 32'(stim_e));
      end
    end
  end

  task automatic pulse_start(input bit sel, input logic [9:0] fs, input logic [9:0] fe);
    @(negedge clk);
    if (sel) begin fid_start2 = fs; fid_end2 = fe; start2 = 1'b1; end
    else     begin fid_start  = fs; fid_end  = fe; start  = 1'b1; end
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int budget, output int cyc);
    cyc = 0;
    while (!(sel ? done2 : done) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check(sel ? "done2_seen" : "done_seen", 32'(sel ? done2 : done), 32'd1);
  endtask

  task automatic post_done(input bit sel);
    @(negedge clk);
    check("done_one_cycle", 32'(sel ? done2 : done), 32'd0);
    check("busy_cleared", 32'(sel ? busy2 : busy), 32'd0);
  endtask

  task automatic run_sweep(input int mode, input bit retrigger);
    int         cyc;
    logic [9:0] cnt_v;
    cnt_v = '0;
    fault_mode = mode;
    for (int i = 0; i < 4; i++) begin
      if (hit_tab[mode][i]) cnt_v = cnt_v + 10'd1;
      exp_q.push_back('{fid: 10'(i), hit: hit_tab[mode][i], cnt: cnt_v});
    end
    pulse_start(1'b0, 10'd0, 10'd4);
    if (retrigger) begin
      repeat (50) @(negedge clk);
      pulse_start(1'b0, 10'd7, 10'd9);
      check("busy_after_retrigger", 32'(busy), 32'd1);
    end
    wait_done(1'b0, 12000, cyc);
    // golden + 4 fault passes of 512*4 cycles, plus 4 REPORT cycles
    if (!retrigger) check("sweep_cycles", 32'(cyc), 32'd10244);
    check("sweep_det_count", 32'(det_count), 32'(cnt_v));
    check("sweep_pending", 32'(exp_q.size()), 32'd0);
    post_done(1'b0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    start = 1'b0; fid_start = '0; fid_end = '0;
    start2 = 1'b0; fid_start2 = '0; fid_end2 = '0;
    repeat (3) @(negedge clk);
    check("reset_a", 32'({stim, fault_id, fault_en, busy, done, det_valid}), 32'd0);
    check("reset_b", 32'({det_fid, det_hit, det_count}), 32'd0);
    check("reset_small", 32'({stim2, busy2, done2, det_valid2, fault_en2}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // short pass: stim phases, golden-only timing
    foreach (stim_tab[i]) stim_q.push_back(stim_tab[i]);
    stim_chk = 1'b1;
    pulse_start(1'b1, 10'd5, 10'd5);
    wait_done(1'b1, 50, cyc);
    stim_chk = 1'b0;
    check("small_golden_cycles", 32'(cyc), 32'd8);
    check("small_stim_count", 32'(stim_q.size()), 32'd0);
    check("small_golden_count", 32'(det_count2), 32'd0);
    post_done(1'b1);

    // fault IDs at the top of the range
    exp2_q.push_back('{fid: 10'd1021, hit: 1'b0, cnt: 10'd0});
    exp2_q.push_back('{fid: 10'd1022, hit: 1'b0, cnt: 10'd0});
    pulse_start(1'b1, 10'd1021, 10'd1023);
    wait_done(1'b1, 100, cyc);
    check("top_range_pending", 32'(exp2_q.size()), 32'd0);
    check("top_range_fault_id", 32'({fault_en2, fault_id2}), 32'd0);
    post_done(1'b1);

    // full campaigns on the default instance
    run_sweep(0, 1'b1);
    run_sweep(1, 1'b0);
    run_sweep(2, 1'b0);

    // reset mid-SWEEP, then a fresh golden-only campaign
    fault_mode = 0;
    pulse_start(1'b0, 10'd0, 10'd4);
    cyc = 0;
    while (!fault_en && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("sweep_entered", 32'(fault_en), 32'd1);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_a", 32'({stim, fault_id, fault_en, busy, done, det_valid}), 32'd0);
    check("midreset_b", 32'({det_fid, det_hit, det_count}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulse_start(1'b0, 10'd5, 10'd5);
    wait_done(1'b0, 2200, cyc);
    check("restart_golden_cycles", 32'(cyc), 32'd2048);
    check("restart_det_count", 32'(det_count), 32'd0);
    post_done(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
